// File: rtl/stream_mem_invoker.sv
// Stream-fed scratch memory that is loaded from an upstream stream, handed to an
// attached Calyx-style kernel through a single-port memory interface, and drained downstream.
module stream_mem_invoker #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [WIDTH-1:0]    s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [WIDTH-1:0]    m_data,
  output logic                kernel_go,
  input  logic                kernel_done,
  input  logic [IDX_SIZE-1:0] mem_addr0,
  input  logic [WIDTH-1:0]    mem_write_data,
  input  logic                mem_write_en,
  output logic [WIDTH-1:0]    mem_read_data,
  output logic                mem_done
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD   | accepting SIZE words from the upstream stream
  // RUN    | kernel owns the memory port until kernel_done
  // DRAIN  | presenting SIZE words downstream
  // FINISH | one-cycle done pulse
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [2:0]          state, state_nxt;
  logic [IDX_SIZE:0]   idx, idx_nxt;
  logic [WIDTH-1:0]    mem [SIZE];
  logic [AW-1:0]       idx_a;
  logic [AW-1:0]       kaddr_a;
  logic                kaddr_ok;
  logic                idx_last;
  logic                s_hs;
  logic                m_hs;
  logic                k_wr;

  assign idx_a    = AW'(idx);
  assign kaddr_a  = AW'(mem_addr0);
  assign kaddr_ok = (32'(mem_addr0) < 32'(SIZE));
  assign idx_last = (32'(idx) == 32'(SIZE - 1));

  assign s_hs = (state == LOAD) && s_valid;
  assign m_hs = (state == DRAIN) && m_ready;
  assign k_wr = (state == RUN) && mem_write_en;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          idx_nxt   = '0;
        end
      end
      LOAD: begin
        if (s_hs) begin
          if (idx_last) begin
            state_nxt = RUN;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      RUN: begin
        if (kernel_done) begin
          state_nxt = DRAIN;
          idx_nxt   = '0;
        end
      end
      DRAIN: begin
        if (m_hs) begin
          if (idx_last) begin
            state_nxt = FINISH;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Out-of-range kernel writes are dropped but still acknowledged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      mem_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      mem_done <= k_wr;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (s_hs) begin
      mem[idx_a] <= s_data;
    end else if (k_wr && kaddr_ok) begin
      mem[kaddr_a] <= mem_write_data;
    end
  end

  assign busy          = (state != IDLE);
  assign done          = (state == FINISH);
  assign s_ready       = (state == LOAD);
  assign m_valid       = (state == DRAIN);
  assign kernel_go     = (state == RUN);
  assign m_data        = m_valid ? mem[idx_a] : '0;
  assign mem_read_data = ((state == RUN) && kaddr_ok) ? mem[kaddr_a] : '0;

endmodule

// File: tb/tb_stream_mem_invoker.sv
// Bench for stream_mem_invoker: directed table of jobs, reset/ignore corner cases,
// then randomized jobs checked against an array model of load, kernel writes and drain.
module tb_stream_mem_invoker;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int IW = 4;

  typedef logic [N-1:0][W-1:0] words_t;

  typedef struct {
    words_t      din;
    logic [W-1:0] add;
    int          gap;
    int          stall;
    bit          kd;
    bit          idle_wr;
    bit          wr5;
    bit          hold;
    words_t      exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          kernel_go;
  logic          kernel_done;
  logic [IW-1:0] mem_addr0;
  logic [W-1:0]  mem_write_data;
  logic          mem_write_en;
  logic [W-1:0]  mem_read_data;
  logic          mem_done;

  int vectors = 0;
  int miscompares = 0;
  vec_t tbl[4];

  stream_mem_invoker #(.WIDTH(W), .SIZE(N), .IDX_SIZE(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .kernel_go(kernel_go), .kernel_done(kernel_done),
    .mem_addr0(mem_addr0), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read_data(mem_read_data), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_start(input bit hold);
    check("idle_busy", 32'(busy), 0);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("load_s_ready", 32'(s_ready), 1);
    check("load_kernel_go", 32'(kernel_go), 0);
  endtask

  task automatic do_load(input words_t din, input int gap, input bit kd);
    int n = 0;
    int guard = 0;
    bit acc;
    while (n < N && guard < 400) begin
      s_valid     = ($urandom_range(99) >= gap);
      s_data      = s_valid ? din[n] : $urandom;
      kernel_done = kd && (guard == 0);
      acc         = s_valid && s_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) n++;
    end
    s_valid     = 1'b0;
    kernel_done = 1'b0;
    check("load_count", n, N);
    check("run_kernel_go", 32'(kernel_go), 1);
    check("run_s_ready", 32'(s_ready), 0);
  endtask

  task automatic kernel_write(input int a, input logic [W-1:0] d, input logic [W-1:0] old);
    mem_addr0      = IW'(a);
    mem_write_data = d;
    mem_write_en   = 1'b1;
    #1;
    check("k_read_old", mem_read_data, old);
    @(posedge clk); #1;
    mem_write_en = 1'b0;
    check("k_mem_done", 32'(mem_done), 1);
  endtask

  task automatic do_kernel(input logic [W-1:0] add, input bit wr5, input int nrand,
                           inout words_t model);
    logic [W-1:0] rd;
    int a;
    logic [W-1:0] d;
    if (wr5) kernel_write(5, 32'h5555_5555, 0);
    for (int i = 0; i < N; i++) begin
      mem_addr0 = IW'(i);
      #1;
      rd = mem_read_data;
      check("k_read", rd, model[i]);
      kernel_write(i, rd + add, model[i]);
      model[i] = model[i] + add;
    end
    for (int k = 0; k < nrand; k++) begin
      a = $urandom_range(7);
      d = $urandom;
      if ($urandom_range(1) == 1) begin
        @(posedge clk); #1;
        check("k_mem_done_idle", 32'(mem_done), 0);
      end
      kernel_write(a, d, (a < N) ? model[a] : '0);
      if (a < N) model[a] = d;
    end
    kernel_done = 1'b1;
    @(posedge clk); #1;
    kernel_done = 1'b0;
    check("drain_kernel_go", 32'(kernel_go), 0);
    check("drain_mem_done", 32'(mem_done), 0);
  endtask

  task automatic do_drain(input words_t exp, input int stall, input bit rand_rdy);
    int n = 0;
    int guard = 0;
    int left = stall;
    bit acc;
    while (n < N && guard < 400) begin
      if (n == 1 && left > 0) begin
        m_ready = 1'b0;
        left--;
      end else begin
        m_ready = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
      end
      check("m_valid", 32'(m_valid), 1);
      check("m_data", m_data, exp[n]);
      check("drain_done_low", 32'(done), 0);
      acc = m_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) n++;
    end
    m_ready = 1'b0;
    check("drain_count", n, N);
    check("finish_done", 32'(done), 1);
    check("finish_m_valid", 32'(m_valid), 0);
    @(posedge clk); #1;
    check("post_done", 32'(done), 0);
    check("post_busy", 32'(busy), 0);
  endtask

  task automatic run_job(input vec_t v, input int nrand, input bit rand_rdy, input bit use_model);
    words_t model;
    if (v.idle_wr) begin
      mem_addr0      = '0;
      mem_write_data = 32'hFFFF_FFFF;
      mem_write_en   = 1'b1;
      #1;
      check("idle_read_zero", mem_read_data, 0);
      @(posedge clk); #1;
      mem_write_en = 1'b0;
      check("idle_mem_done", 32'(mem_done), 0);
    end
    do_start(v.hold);
    do_load(v.din, v.gap, v.kd);
    model = v.din;
    do_kernel(v.add, v.wr5, nrand, model);
    do_drain(use_model ? model : v.exp, v.stall, rand_rdy);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    tbl[0] = '{din: {32'd4, 32'd3, 32'd2, 32'd1}, add: 32'd10, gap: 0, stall: 0,
               kd: 0, idle_wr: 0, wr5: 0, hold: 0, exp: {32'd14, 32'd13, 32'd12, 32'd11}};
    tbl[1] = '{din: {32'd4, 32'd3, 32'd2, 32'd1}, add: 32'd10, gap: 50, stall: 3,
               kd: 0, idle_wr: 0, wr5: 0, hold: 1, exp: {32'd14, 32'd13, 32'd12, 32'd11}};
    tbl[2] = '{din: {32'd400, 32'd300, 32'd200, 32'd100}, add: 32'd1, gap: 0, stall: 0,
               kd: 1, idle_wr: 1, wr5: 0, hold: 0, exp: {32'd401, 32'd301, 32'd201, 32'd101}};
    tbl[3] = '{din: {32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF}, add: 32'd1, gap: 20,
               stall: 1, kd: 0, idle_wr: 0, wr5: 1, hold: 0,
               exp: {32'h8000_0001, 32'h8000_0000, 32'h1, 32'h0}};

    reset = 1'b1; start = 0; s_valid = 0; s_data = 0; m_ready = 0;
    kernel_done = 0; mem_addr0 = 0; mem_write_data = 0; mem_write_en = 0;
    #3;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_kernel_go", 32'(kernel_go), 0);
    check("rst_mem_done", 32'(mem_done), 0);
    check("rst_m_data", m_data, 0);
    #9 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_job(tbl[i], 0, 1'b0, 1'b0);

    // Reset asserted between edges while the kernel owns the memory.
    do_start(1'b0);
    do_load(tbl[0].din, 0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midrst_kernel_go", 32'(kernel_go), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_s_ready", 32'(s_ready), 0);
    @(posedge clk); #1;
    check("midrst_done", 32'(done), 0);
    check("midrst_busy_edge", 32'(busy), 0);
    reset = 1'b0;
    run_job(tbl[0], 0, 1'b0, 1'b0);

    for (int j = 0; j < 20; j++) begin
      rv = tbl[0];
      for (int k = 0; k < N; k++) rv.din[k] = $urandom;
      rv.add   = $urandom;
      rv.gap   = $urandom_range(60);
      rv.stall = $urandom_range(3);
      rv.hold  = $urandom_range(1) == 1;
      run_job(rv, $urandom_range(1, 6), 1'b1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
